// File: rtl/accum_requant_writer.sv
// Drain stage between a peek-style partial-sum FIFO and a dual-port memory.
// Accumulates groups of num_acc int32 vectors per lane. Each lane sum is
// requantized to int8 with a rounding arithmetic right shift and saturation.
// One packed vector per group is written to consecutive addresses.
module accum_requant_writer #(
    parameter int LANES = 4,
    parameter int ACCW  = 32,
    parameter int OUTW  = 8,
    parameter int ADDRW = 9,
    parameter int CNTW  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNTW-1:0]         num_acc,
    input  logic [ADDRW:0]          num_out,
    input  logic [ADDRW-1:0]        base_addr,
    input  logic [4:0]              shift,
    output logic                    busy,
    output logic                    done,
    input  logic                    fifo_empty,
    input  logic [LANES*ACCW-1:0]   fifo_odata,
    output logic                    fifo_pop,
    output logic [ADDRW-1:0]        mem_waddr,
    output logic                    mem_wen,
    output logic [LANES*OUTW-1:0]   mem_wdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCUM   = 3'd1;
    localparam logic [2:0] S_REQUANT = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // Saturation bounds of the int8 output, held in the widened requant width
    localparam logic signed [ACCW:0] SAT_HI = (ACCW+1)'((1 << (OUTW-1)) - 1);
    localparam logic signed [ACCW:0] SAT_LO = ~SAT_HI;

    logic [2:0]                 state;
    logic [CNTW-1:0]            num_acc_q;
    logic [ADDRW:0]             num_out_q;
    logic [ADDRW-1:0]           base_q;
    logic [4:0]                 shift_q;
    logic [CNTW-1:0]            grp_cnt;
    logic [ADDRW:0]             out_idx;
    logic signed [ACCW-1:0]     lane_p0 [LANES];
    logic signed [ACCW-1:0]     acc_p0  [LANES];
    logic [LANES*OUTW-1:0]      rq_p1;
    logic                       grp_last;
    logic                       out_last;

    // Round half up: add 2^(sh-1) in one extra bit so the bias cannot overflow
    function automatic logic signed [ACCW:0] round_shift(
        input logic signed [ACCW-1:0] a,
        input logic [4:0]             sh
    );
        logic signed [ACCW:0] ext;
        logic signed [ACCW:0] bias;
        ext  = {a[ACCW-1], a};
        bias = (sh == 5'd0) ? '0 : ((ACCW+1)'(1) << (sh - 5'd1));
        return (ext + bias) >>> sh;
    endfunction

    // Clamp the shifted value into the signed output range
    function automatic logic [OUTW-1:0] saturate(input logic signed [ACCW:0] r);
        if (r > SAT_HI)
            return SAT_HI[OUTW-1:0];
        else if (r < SAT_LO)
            return SAT_LO[OUTW-1:0];
        else
            return r[OUTW-1:0];
    endfunction

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign fifo_pop = (state == S_ACCUM) && !fifo_empty;
    assign grp_last = (grp_cnt == (num_acc_q - CNTW'(1)));
    assign out_last = ((out_idx + (ADDRW+1)'(1)) == num_out_q);

    // Unpack the FIFO head into per-lane signed partial sums
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_p0[i] = fifo_odata[i*ACCW +: ACCW];
        end
    end

    // Requantize every lane accumulator into the packed output word
    always_comb begin
        rq_p1 = '0;
        for (int i = 0; i < LANES; i++) begin
            rq_p1[i*OUTW +: OUTW] = saturate(round_shift(acc_p0[i], shift_q));
        end
    end

    // Job control FSM, lane accumulators and registered memory write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            num_acc_q <= '0;
            num_out_q <= '0;
            base_q    <= '0;
            shift_q   <= '0;
            grp_cnt   <= '0;
            out_idx   <= '0;
            mem_waddr <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc_p0[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_acc_q <= (num_acc == '0) ? CNTW'(1) : num_acc;
                        num_out_q <= num_out;
                        base_q    <= base_addr;
                        shift_q   <= shift;
                        grp_cnt   <= '0;
                        out_idx   <= '0;
                        state     <= (num_out == '0) ? S_DONE : S_ACCUM;
                    end
                end
                // stage p0: consume one FIFO word per cycle into the lane sums
                S_ACCUM: begin
                    if (fifo_pop) begin
                        for (int i = 0; i < LANES; i++) begin
                            acc_p0[i] <= (grp_cnt == '0) ? lane_p0[i]
                                                         : acc_p0[i] + lane_p0[i];
                        end
                        if (grp_last) begin
                            grp_cnt <= '0;
                            state   <= S_REQUANT;
                        end else begin
                            grp_cnt <= grp_cnt + CNTW'(1);
                        end
                    end
                end
                // stage p1: register the requantized word and its address
                S_REQUANT: begin
                    mem_wdata <= rq_p1;
                    mem_waddr <= base_q + out_idx[ADDRW-1:0];
                    mem_wen   <= 1'b1;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    mem_wen <= 1'b0;
                    out_idx <= out_idx + (ADDRW+1)'(1);
                    state   <= out_last ? S_DONE : S_ACCUM;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_requant_writer.sv
// Directed bench for accum_requant_writer: FIFO model, write/done/pop monitors
// and one task per scenario with hand-computed expected words.
module tb_accum_requant_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   num_acc;
    logic [9:0]   num_out;
    logic [8:0]   base_addr;
    logic [4:0]   shift;
    logic         busy;
    logic         done;
    logic         fifo_empty;
    logic [127:0] fifo_odata;
    logic         fifo_pop;
    logic [8:0]   mem_waddr;
    logic         mem_wen;
    logic [31:0]  mem_wdata;

    accum_requant_writer #(
        .LANES(4), .ACCW(32), .OUTW(8), .ADDRW(9), .CNTW(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_acc(num_acc),
        .num_out(num_out), .base_addr(base_addr), .shift(shift),
        .busy(busy), .done(done), .fifo_empty(fifo_empty),
        .fifo_odata(fifo_odata), .fifo_pop(fifo_pop),
        .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO model: written by the stimulus, read pointer advanced on pop
    logic [127:0] fmem [0:255];
    logic [7:0]   wr_ptr = 8'd0;
    logic [7:0]   rd_ptr = 8'd0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_odata = fmem[rd_ptr];

    // Monitors
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          pop_cnt = 0;
    int          viol = 0;
    logic [8:0]  wa  [0:63];
    logic [31:0] wd  [0:63];
    int          wcy [0:63];
    int          t_start = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wen) begin
            wa[wr_cnt]  <= mem_waddr;
            wd[wr_cnt]  <= mem_wdata;
            wcy[wr_cnt] <= cyc;
            wr_cnt      <= wr_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (fifo_pop) begin
            rd_ptr  <= rd_ptr + 8'd1;
            pop_cnt <= pop_cnt + 1;
            if (fifo_empty) viol <= viol + 1;
        end
    end

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic push(input int a, input int b, input int c, input int d);
        fmem[wr_ptr] = {d, c, b, a};
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic kick(input int na, input int no, input int ba, input int sh);
        num_acc   = na[7:0];
        num_out   = no[9:0];
        base_addr = ba[8:0];
        shift     = sh[4:0];
        start     = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b expected 0", mem_wen); end
        checks++; if (mem_waddr !== 9'd0) begin errors++; $display("FAIL reset_waddr: got %0h expected 0", mem_waddr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", mem_wdata); end
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %0b expected 0", fifo_pop); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int w0, p0, d0;
        bit ok;
        w0 = wr_cnt; p0 = pop_cnt; d0 = done_cnt;
        repeat (3) push(1, 2, 3, 4);
        kick(3, 1, 5, 0);
        wait_done(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL basic_writes: got %0d expected 1", wr_cnt - w0); end
        checks++; if (wa[w0] !== 9'd5) begin errors++; $display("FAIL basic_addr: got %0d expected 5", wa[w0]); end
        checks++; if (wd[w0] !== pk(3, 6, 9, 12)) begin errors++; $display("FAIL basic_data: got %0h expected %0h", wd[w0], pk(3, 6, 9, 12)); end
        checks++; if (pop_cnt - p0 !== 3) begin errors++; $display("FAIL basic_pops: got %0d expected 3", pop_cnt - p0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt - d0); end
        checks++; if (done_cyc - wcy[w0] !== 1) begin errors++; $display("FAIL basic_done_lag: got %0d expected 1", done_cyc - wcy[w0]); end
        checks++; if (wcy[w0] - t_start !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", wcy[w0] - t_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_round_sat();
        int w0;
        bit ok;
        w0 = wr_cnt;
        push(5, -5, 1000, -1000);
        kick(1, 1, 0, 1);
        wait_done(30, ok);
        push(1000, 0, -6, 7);
        kick(1, 1, 1, 2);
        wait_done(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL round_timeout: got no done expected done"); end
        checks++; if (wd[w0] !== pk(3, -2, 127, -128)) begin errors++; $display("FAIL round_shift1: got %0h expected %0h", wd[w0], pk(3, -2, 127, -128)); end
        checks++; if (wd[w0+1] !== pk(127, 0, -1, 2)) begin errors++; $display("FAIL round_shift2: got %0h expected %0h", wd[w0+1], pk(127, 0, -1, 2)); end
    endtask

    task automatic test_stall();
        int w0, p0;
        bit ok;
        w0 = wr_cnt;
        push(10, 20, 30, 40); push(1, 1, 1, 1); push(-3, 5, 0, 100); push(2, 2, 2, 2);
        kick(4, 1, 20, 1);
        wait_done(30, ok);
        checks++; if (wcy[w0] - t_start !== 5) begin errors++; $display("FAIL stall_lat_nogap: got %0d expected 5", wcy[w0] - t_start); end
        checks++; if (wd[w0] !== pk(5, 14, 17, 72)) begin errors++; $display("FAIL stall_data_nogap: got %0h expected %0h", wd[w0], pk(5, 14, 17, 72)); end
        p0 = pop_cnt;
        push(10, 20, 30, 40); push(1, 1, 1, 1);
        kick(4, 1, 21, 1);
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < 5; k++) begin
            checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL stall_gap_pop: got %0b expected 0 at gap cycle %0d", fifo_pop, k); end
            @(posedge clk); #1;
        end
        push(-3, 5, 0, 100); push(2, 2, 2, 2);
        wait_done(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got no done expected done"); end
        checks++; if (pop_cnt - p0 !== 4) begin errors++; $display("FAIL stall_pops: got %0d expected 4", pop_cnt - p0); end
        checks++; if (wcy[w0+1] - t_start !== 10) begin errors++; $display("FAIL stall_lat_gap: got %0d expected 10", wcy[w0+1] - t_start); end
        checks++; if (wd[w0+1] !== pk(5, 14, 17, 72)) begin errors++; $display("FAIL stall_data_gap: got %0h expected %0h", wd[w0+1], pk(5, 14, 17, 72)); end
        checks++; if (wa[w0+1] !== 9'd21) begin errors++; $display("FAIL stall_addr: got %0d expected 21", wa[w0+1]); end
    endtask

    task automatic test_wrap_multi();
        int w0, d0, drop;
        bit ok;
        logic [8:0] ea;
        w0 = wr_cnt; d0 = done_cnt; drop = 0; ok = 1'b0;
        for (int k = 0; k < 4; k++) push(k + 1, -(k + 1), 0, 200);
        kick(1, 4, 510, 0);
        for (int i = 0; i < 40; i++) begin
            if (done) begin ok = 1'b1; break; end
            if (!busy) drop++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got no done expected done"); end
        checks++; if (drop !== 0) begin errors++; $display("FAIL wrap_busy: got %0d idle cycles expected 0", drop); end
        checks++; if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL wrap_writes: got %0d expected 4", wr_cnt - w0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL wrap_done_cnt: got %0d expected 1", done_cnt - d0); end
        for (int k = 0; k < 4; k++) begin
            ea = (k < 2) ? 9'(510 + k) : 9'(k - 2);
            checks++; if (wa[w0+k] !== ea) begin errors++; $display("FAIL wrap_addr%0d: got %0d expected %0d", k, wa[w0+k], ea); end
            checks++; if (wd[w0+k] !== pk(k + 1, -(k + 1), 0, 127)) begin errors++; $display("FAIL wrap_data%0d: got %0h expected %0h", k, wd[w0+k], pk(k + 1, -(k + 1), 0, 127)); end
        end
    endtask

    task automatic test_degenerate();
        int w0, p0, d0;
        bit ok;
        w0 = wr_cnt; p0 = pop_cnt; d0 = done_cnt;
        push(7, -8, 9, -10);
        kick(5, 0, 33, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_out_done: got %0b expected 1", done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_out_idle: got done=%0b busy=%0b expected 0 0", done, busy); end
        checks++; if (pop_cnt - p0 !== 0 || wr_cnt - w0 !== 0) begin errors++; $display("FAIL zero_out_activity: got pops=%0d writes=%0d expected 0 0", pop_cnt - p0, wr_cnt - w0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL zero_out_done_cnt: got %0d expected 1", done_cnt - d0); end
        kick(0, 1, 40, 0);
        wait_done(30, ok);
        checks++; if (pop_cnt - p0 !== 1 || wr_cnt - w0 !== 1) begin errors++; $display("FAIL zero_acc_counts: got pops=%0d writes=%0d expected 1 1", pop_cnt - p0, wr_cnt - w0); end
        checks++; if (wd[w0] !== pk(7, -8, 9, -10) || wa[w0] !== 9'd40) begin errors++; $display("FAIL zero_acc_write: got %0h@%0d expected %0h@40", wd[w0], wa[w0], pk(7, -8, 9, -10)); end
        w0 = wr_cnt; p0 = pop_cnt;
        push(1, 1, 1, 1); push(2, 2, 2, 2);
        kick(2, 1, 50, 0);
        kick(1, 3, 99, 3);
        wait_done(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_start_timeout: got no done expected done"); end
        checks++; if (wr_cnt - w0 !== 1 || pop_cnt - p0 !== 2) begin errors++; $display("FAIL busy_start_counts: got writes=%0d pops=%0d expected 1 2", wr_cnt - w0, pop_cnt - p0); end
        checks++; if (wd[w0] !== 32'h03030303 || wa[w0] !== 9'd50) begin errors++; $display("FAIL busy_start_write: got %0h@%0d expected 03030303@50", wd[w0], wa[w0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int w0, p0;
        bit ok;
        push(100, 100, 100, 100); push(100, 100, 100, 100);
        kick(4, 1, 60, 0);
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || fifo_pop !== 1'b0 || mem_wen !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got busy=%0b pop=%0b wen=%0b expected 0 0 0", busy, fifo_pop, mem_wen); end
        checks++; if (mem_waddr !== 9'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL midrst_data: got %0h@%0d expected 0@0", mem_wdata, mem_waddr); end
        @(posedge clk); #1;
        rst = 1'b1;
        w0 = wr_cnt; p0 = pop_cnt;
        push(4, 5, 6, 7); push(1, 1, 1, 1);
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (pop_cnt - p0 !== 0 || wr_cnt - w0 !== 0) begin errors++; $display("FAIL midrst_quiet: got pops=%0d writes=%0d expected 0 0", pop_cnt - p0, wr_cnt - w0); end
        kick(2, 1, 60, 0);
        wait_done(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout: got no done expected done"); end
        checks++; if (wr_cnt - w0 !== 1 || wd[w0] !== pk(5, 6, 7, 8) || wa[w0] !== 9'd60) begin errors++; $display("FAIL midrst_fresh: got %0d writes %0h@%0d expected 1 %0h@60", wr_cnt - w0, wd[w0], wa[w0], pk(5, 6, 7, 8)); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; num_acc = '0; num_out = '0; base_addr = '0; shift = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_round_sat();
        test_stall();
        test_wrap_multi();
        test_degenerate();
        test_reset_mid();
        checks++; if (viol !== 0) begin errors++; $display("FAIL pop_while_empty: got %0d expected 0", viol); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
